// File: rtl/disp_pkg.sv
// Shared types, sizes and helpers for the multiplexed 4-digit display scanner.
package disp_pkg;

  localparam int unsigned NUM_DIGITS       = 4;
  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned DATA_W           = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned IDX_W            = 2;
  localparam int unsigned SCAN_DIV_DEFAULT = 50000;

  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [NIBBLE_W-1:0]   nibble_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [NUM_DIGITS-1:0] sel_t;

  function automatic nibble_t nibble_of(data_t d, idx_t idx);
    return nibble_t'(d >> (NIBBLE_W * 32'(idx)));
  endfunction

  // A digit is a leading zero when it and every more-significant digit are zero.
  function automatic logic digit_blank(data_t d, idx_t idx, bit blank_lead);
    data_t upper;
    upper = d >> (NIBBLE_W * 32'(idx));
    return blank_lead && (idx != '0) && (upper == '0);
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Load handshake plus scanned-digit outputs of the display scanner.
interface disp_scan_ctrl_if;

  logic              in_valid;
  logic              in_ready;
  disp_pkg::data_t   in_data;
  disp_pkg::nibble_t nibble;
  disp_pkg::sel_t    digit_en;
  logic              blank;
  logic              frame_tick;

  modport master (
    output in_valid, in_data,
    input  in_ready, nibble, digit_en, blank, frame_tick
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, nibble, digit_en, blank, frame_tick
  );

endinterface

// File: rtl/disp_prescaler.sv
// Free-running divider producing one slot_tick every SCAN_DIV clock cycles.
module disp_prescaler #(
  parameter int unsigned SCAN_DIV = disp_pkg::SCAN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_div
    $error("disp_prescaler: SCAN_DIV out of range 2..65535");
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  assign slot_tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = slot_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit display scanner: double-buffered load, frame-aligned update and
// optional leading-zero blanking.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = SCAN_DIV_DEFAULT,
  parameter int unsigned BLANK_LEAD = 1
) (
  input logic              clk,
  input logic              rst_n,
  disp_scan_ctrl_if.slave  bus_io
);

  logic    slot_tick;
  logic    frame_tick;
  logic    load;
  idx_t    idx_q, idx_d;
  data_t   disp_q, disp_d;
  data_t   pend_q, pend_d;
  logic    pend_full_q, pend_full_d;
  nibble_t nibble_q, nibble_d;
  sel_t    digit_en_q, digit_en_d;
  logic    blank_q, blank_d;

  disp_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_tick (slot_tick)
  );

  always_comb begin
    frame_tick  = slot_tick && (idx_q == idx_t'(NUM_DIGITS - 1));
    load        = bus_io.in_valid && !pend_full_q;
    idx_d       = slot_tick ? idx_q + 1'b1 : idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    // Transfer and load are exclusive: a load needs pending empty, a transfer needs it full.
    if (frame_tick && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (load) begin
      pend_d      = bus_io.in_data;
      pend_full_d = 1'b1;
    end

    // Outputs are computed from next-state so they change on the same edge as idx.
    nibble_d   = nibble_of(disp_d, idx_d);
    blank_d    = digit_blank(disp_d, idx_d, BLANK_LEAD != 0);
    digit_en_d = blank_d ? '0 : sel_t'(1) << idx_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      nibble_q    <= '0;
      digit_en_q  <= sel_t'(1);
      blank_q     <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      nibble_q    <= nibble_d;
      digit_en_q  <= digit_en_d;
      blank_q     <= blank_d;
    end
  end

  assign bus_io.in_ready   = !pend_full_q;
  assign bus_io.nibble     = nibble_q;
  assign bus_io.digit_en   = digit_en_q;
  assign bus_io.blank      = blank_q;
  assign bus_io.frame_tick = frame_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs, a monitor checks them.
module tb_disp_scan_ctrl;

  localparam int D = 4;

  typedef struct packed {
    logic       rdy;
    logic [3:0] nib;
    logic [3:0] en;
    logic       blk;
    logic       ft;
  } obs_t;

  typedef struct packed {
    obs_t o1;
    obs_t o0;
  } exp_t;

  localparam obs_t RstObs = '{rdy: 1'b1, nib: 4'h0, en: 4'b0001, blk: 1'b0, ft: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Model state: cycles since reset release, displayed word, pending buffer.
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_full;

  disp_scan_ctrl_if bus1 ();
  disp_scan_ctrl_if bus0 ();

  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;

  disp_scan_ctrl #(.SCAN_DIV(D), .BLANK_LEAD(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus1)
  );

  disp_scan_ctrl #(.SCAN_DIV(D), .BLANK_LEAD(0)) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus0)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_obs(int t, logic [15:0] disp, bit full, bit lead);
    obs_t o;
    int   slot;
    int   hi;
    int   dig[4];
    slot = (t / D) % 4;
    hi   = 0;
    for (int k = 0; k < 4; k++) begin
      dig[k] = int'((disp >> (4 * k)) & 16'hF);
      if (dig[k] != 0) hi = k;
    end
    o.rdy = !full;
    o.nib = 4'(dig[slot]);
    o.blk = lead && (slot > hi);
    o.en  = o.blk ? 4'b0000 : 4'(1 << slot);
    o.ft  = (t % (4 * D)) == (4 * D - 1);
    return o;
  endfunction

  function automatic obs_t get_obs(logic rdy, logic [3:0] nib, logic [3:0] en, logic blk,
                                   logic ft);
    obs_t o;
    o.rdy = rdy;
    o.nib = nib;
    o.en  = en;
    o.blk = blk;
    o.ft  = ft;
    return o;
  endfunction

  task automatic check(string name, obs_t got, obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t got rdy=%b nib=%h en=%b blk=%b ft=%b want rdy=%b nib=%h en=%b blk=%b ft=%b",
               name, $time, got.rdy, got.nib, got.en, got.blk, got.ft,
               want.rdy, want.nib, want.en, want.blk, want.ft);
    end
  endtask

  // Reference model: advances at each clock, resets on rst_n fall, queues the expectation.
  initial begin
    exp_t e;
    m_t = 0; m_disp = '0; m_pend = '0; m_full = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t = 0; m_disp = '0; m_pend = '0; m_full = 1'b0;
        exp_q.delete();
      end else begin
        if ((m_t % (4 * D)) == (4 * D - 1) && m_full) begin
          m_disp = m_pend;
          m_full = 1'b0;
        end else if (in_valid && !m_full) begin
          m_pend = in_data;
          m_full = 1'b1;
        end
        m_t++;
      end
      e.o1 = model_obs(m_t, m_disp, m_full, 1'b1);
      e.o0 = model_obs(m_t, m_disp, m_full, 1'b0);
      exp_q.push_back(e);
    end
  end

  // Monitor: compares every cycle; a reset fall while clk is high is checked asynchronously.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (clk) begin
        #1;
        check("async_rst_lead1", get_obs(bus1.in_ready, bus1.nibble, bus1.digit_en, bus1.blank,
                                         bus1.frame_tick), RstObs);
        check("async_rst_lead0", get_obs(bus0.in_ready, bus0.nibble, bus0.digit_en, bus0.blank,
                                         bus0.frame_tick), RstObs);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty @%0t got 0 entries want 1", $time);
      end else begin
        e = exp_q.pop_front();
        check("scan_lead1", get_obs(bus1.in_ready, bus1.nibble, bus1.digit_en, bus1.blank,
                                    bus1.frame_tick), e.o1);
        check("scan_lead0", get_obs(bus0.in_ready, bus0.nibble, bus0.digit_en, bus0.blank,
                                    bus0.frame_tick), e.o0);
      end
    end
  end

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus1.in_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL in_ready_timeout got 0 want 1 within 200 cycles");
        $fatal(1, "handshake stalled");
      end
    end
  endtask

  task automatic send(logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    wait_ready();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frame_tick();
    int n;
    n = 0;
    while (!bus1.frame_tick) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL frame_tick_timeout got 0 want 1 within 200 cycles");
        $fatal(1, "no frame_tick");
      end
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #7 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    idle(40);
    idle(6);
    send(16'h1234);
    idle(40);
    send(16'h0050);
    idle(40);
    send(16'hAAAA);
    send(16'h5555);
    idle(50);

    // Load offered exactly in a frame_tick cycle with pending empty.
    wait_frame_tick();
    in_valid = 1'b1;
    in_data  = 16'h9876;
    @(negedge clk);
    idle(40);

    for (int i = 0; i < 300; i++) begin
      if (!(in_valid && !bus1.in_ready)) begin
        in_valid = ($urandom_range(0, 3) == 0);
        in_data  = 16'($urandom);
      end
      @(negedge clk);
    end
    idle(2);

    // Fill pending, then reset mid-slot before it can reach the display.
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    wait_ready();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(40);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
